// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and RAM signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              if_err;

    logic              ls_req;
    logic              ls_we;
    logic [2:0]        ls_funct3;
    logic [31:0]       ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_ack;
    logic [31:0]       ls_rdata;
    logic              ls_err;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, ram_rdata,
        output if_ack, if_rdata, if_err, ls_ack, ls_rdata, ls_err,
               ram_en, ram_we, ram_addr, ram_be, ram_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, ram_rdata,
        input  if_ack, if_rdata, if_err, ls_ack, ls_rdata, ls_err,
               ram_en, ram_we, ram_addr, ram_be, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/load-store arbiter for a single-port data RAM
module mem_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_n;
    logic              gnt, gnt_n, last_grant, last_grant_n, we_q, we_n;
    logic [2:0]        f3_q, f3_n;
    logic [1:0]        lo_q, lo_n;
    logic              ram_en_n, ram_we_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [3:0]        ram_be_n;
    logic [31:0]       ram_wdata_n;
    logic              if_ack_n, if_err_n, ls_ack_n, ls_err_n;
    logic [31:0]       if_rdata_n, ls_rdata_n;

    logic              pick, c_we, bad;
    logic [31:0]       c_addr, c_wdata;
    logic [2:0]        c_f3;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       rd_fmt;

    // Fetch is treated as a word load so one checker covers both ports.
    always_comb begin
        pick    = (bus.if_req && bus.ls_req) ? ~last_grant : bus.ls_req;
        c_addr  = pick ? bus.ls_addr : bus.if_addr;
        c_f3    = pick ? bus.ls_funct3 : 3'b010;
        c_we    = pick & bus.ls_we;
        c_wdata = pick ? bus.ls_wdata : 32'd0;
        case (c_f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = c_addr[0];
            3'b010:  bad = |c_addr[1:0];
            3'b100:  bad = c_we;
            3'b101:  bad = c_we | c_addr[0];
            default: bad = 1'b1;
        endcase
        if ((c_addr >> (ADDR_W + 2)) != 32'd0) bad = 1'b1;
    end

    always_comb begin
        rd_byte = bus.ram_rdata[{lo_q, 3'b000} +: 8];
        rd_half = lo_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        case (f3_q)
            3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_fmt = {24'd0, rd_byte};
            3'b101:  rd_fmt = {16'd0, rd_half};
            default: rd_fmt = bus.ram_rdata;
        endcase
        if (we_q) rd_fmt = 32'd0;
    end

    // Outputs are computed one state ahead and registered on the transition.
    always_comb begin
        state_n      = state;
        gnt_n        = gnt;
        last_grant_n = last_grant;
        we_n         = we_q;
        f3_n         = f3_q;
        lo_n         = lo_q;
        ram_en_n     = 1'b0;
        ram_we_n     = 1'b0;
        ram_addr_n   = '0;
        ram_be_n     = 4'b0000;
        ram_wdata_n  = 32'd0;
        if_ack_n     = 1'b0;
        ls_ack_n     = 1'b0;
        if_err_n     = bus.if_err;
        ls_err_n     = bus.ls_err;
        if_rdata_n   = bus.if_rdata;
        ls_rdata_n   = bus.ls_rdata;
        case (state)
            IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    gnt_n        = pick;
                    last_grant_n = pick;
                    we_n         = c_we;
                    f3_n         = c_f3;
                    lo_n         = c_addr[1:0];
                    if (bad) begin
                        state_n = RESP;
                        if (pick) begin
                            ls_ack_n   = 1'b1;
                            ls_err_n   = 1'b1;
                            ls_rdata_n = 32'd0;
                        end else begin
                            if_ack_n   = 1'b1;
                            if_err_n   = 1'b1;
                            if_rdata_n = 32'd0;
                        end
                    end else begin
                        state_n    = ISSUE;
                        ram_en_n   = 1'b1;
                        ram_we_n   = c_we;
                        ram_addr_n = c_addr[ADDR_W+1:2];
                        ram_be_n   = 4'b1111;
                        if (c_we) begin
                            case (c_f3[1:0])
                                2'b00: begin
                                    ram_be_n    = 4'b0001 << c_addr[1:0];
                                    ram_wdata_n = {4{c_wdata[7:0]}};
                                end
                                2'b01: begin
                                    ram_be_n    = 4'b0011 << c_addr[1:0];
                                    ram_wdata_n = {2{c_wdata[15:0]}};
                                end
                                default: ram_wdata_n = c_wdata;
                            endcase
                        end
                    end
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                state_n = RESP;
                if (gnt) begin
                    ls_ack_n   = 1'b1;
                    ls_err_n   = 1'b0;
                    ls_rdata_n = rd_fmt;
                end else begin
                    if_ack_n   = 1'b1;
                    if_err_n   = 1'b0;
                    if_rdata_n = rd_fmt;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            gnt           <= 1'b0;
            last_grant    <= 1'b1;
            we_q          <= 1'b0;
            f3_q          <= 3'b000;
            lo_q          <= 2'b00;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_be    <= 4'b0000;
            bus.ram_wdata <= 32'd0;
            bus.if_ack    <= 1'b0;
            bus.if_err    <= 1'b0;
            bus.if_rdata  <= 32'd0;
            bus.ls_ack    <= 1'b0;
            bus.ls_err    <= 1'b0;
            bus.ls_rdata  <= 32'd0;
        end else begin
            state         <= state_n;
            gnt           <= gnt_n;
            last_grant    <= last_grant_n;
            we_q          <= we_n;
            f3_q          <= f3_n;
            lo_q          <= lo_n;
            bus.ram_en    <= ram_en_n;
            bus.ram_we    <= ram_we_n;
            bus.ram_addr  <= ram_addr_n;
            bus.ram_be    <= ram_be_n;
            bus.ram_wdata <= ram_wdata_n;
            bus.if_ack    <= if_ack_n;
            bus.if_err    <= if_err_n;
            bus.if_rdata  <= if_rdata_n;
            bus.ls_ack    <= ls_ack_n;
            bus.ls_err    <= ls_err_n;
            bus.ls_rdata  <= ls_rdata_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural RAM
module tb_mem_arbiter;
    localparam int ADDR_W = 16;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } ack_t;

    typedef struct {
        int          cyc;
        bit          we;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } ram_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ack_t exp_ack[$];
    ram_t exp_ram[$];
    ack_t ea;
    ram_t er;
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    mem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_be[b]) mem[bus.ram_addr[5:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            end else begin
                bus.ram_rdata <= mem[bus.ram_addr[5:0]];
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (bus.if_ack || bus.ls_ack) begin
                total++;
                if (bus.if_ack && bus.ls_ack) begin
                    bad++;
                    $display("FAIL dual_ack: both acks high at cyc %0d, required at most one", cyc);
                end else if (exp_ack.size() == 0) begin
                    bad++;
                    $display("FAIL stray_ack: port %0d ack at cyc %0d, required none", bus.ls_ack, cyc);
                end else begin
                    ea = exp_ack.pop_front();
                    if (ea.port != bus.ls_ack || ea.cyc != cyc ||
                        ea.rdata != (bus.ls_ack ? bus.ls_rdata : bus.if_rdata) ||
                        ea.err != (bus.ls_ack ? bus.ls_err : bus.if_err)) begin
                        bad++;
                        $display("FAIL ack: got port=%0d cyc=%0d rdata=%h err=%0d, required port=%0d cyc=%0d rdata=%h err=%0d",
                                 bus.ls_ack, cyc, bus.ls_ack ? bus.ls_rdata : bus.if_rdata,
                                 bus.ls_ack ? bus.ls_err : bus.if_err, ea.port, ea.cyc, ea.rdata, ea.err);
                    end
                end
            end
            total++;
            if (bus.ram_en) begin
                if (exp_ram.size() == 0) begin
                    bad++;
                    $display("FAIL stray_ram_en: cyc %0d addr=%h, required no RAM access", cyc, bus.ram_addr);
                end else begin
                    er = exp_ram.pop_front();
                    if (er.cyc != cyc || er.we != bus.ram_we || er.addr != bus.ram_addr ||
                        er.be != bus.ram_be || er.wdata != bus.ram_wdata) begin
                        bad++;
                        $display("FAIL ram_cmd: got cyc=%0d we=%0d addr=%h be=%b wdata=%h, required cyc=%0d we=%0d addr=%h be=%b wdata=%h",
                                 cyc, bus.ram_we, bus.ram_addr, bus.ram_be, bus.ram_wdata,
                                 er.cyc, er.we, er.addr, er.be, er.wdata);
                    end
                end
            end else if ({bus.ram_we, bus.ram_be, bus.ram_wdata} != 37'd0) begin
                bad++;
                $display("FAIL ram_idle: we=%0d be=%b wdata=%h with ram_en=0, required all 0",
                         bus.ram_we, bus.ram_be, bus.ram_wdata);
            end
        end
    end

    task automatic chk_zero(input string name);
        logic [121:0] v;
        v = {bus.if_ack, bus.if_rdata, bus.if_err, bus.ls_ack, bus.ls_rdata, bus.ls_err,
             bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_be, bus.ram_wdata};
        total++;
        if (v != 122'd0) begin
            bad++;
            $display("FAIL %s: outputs=%h, required 0", name, v);
        end
    endtask

    task automatic do_req(input bit port, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int   k;
        bit   seen;
        ack_t a;
        ram_t r;
        if (port) begin
            bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_funct3 = f3;
            bus.ls_addr = addr; bus.ls_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        k = cyc;
        a.port = port; a.rdata = exp_rdata; a.err = exp_err; a.cyc = exp_err ? k + 1 : k + 3;
        exp_ack.push_back(a);
        if (!exp_err) begin
            r.cyc = k + 1; r.we = we; r.addr = addr[ADDR_W+1:2]; r.be = exp_be; r.wdata = exp_wdata;
            exp_ram.push_back(r);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = port ? bus.ls_ack : bus.if_ack;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL ack_timeout: port %0d addr %h got no ack in 20 cycles, required ack", port, addr);
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int   k;
        ack_t a;
        ram_t r;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[0] = 32'h80FF7F01;
        mem[4] = 32'hDEADBEEF;
        bus.ram_rdata = 32'd0;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_funct3 = 3'b000;
        bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        reset = 1'b1;
        @(negedge clk);

        do_req(0, 0, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0);
        do_req(1, 1, F_B,  32'h13, 32'h000000A5, 32'h0,        0, 4'b1000, 32'hA5A5A5A5);
        do_req(1, 0, F_B,  32'h1,  32'h0,        32'h0000007F, 0, 4'b1111, 32'h0);
        do_req(1, 0, F_B,  32'h2,  32'h0,        32'hFFFFFFFF, 0, 4'b1111, 32'h0);
        do_req(1, 0, F_BU, 32'h3,  32'h0,        32'h00000080, 0, 4'b1111, 32'h0);
        do_req(1, 0, F_H,  32'h2,  32'h0,        32'hFFFF80FF, 0, 4'b1111, 32'h0);
        do_req(1, 0, F_HU, 32'h2,  32'h0,        32'h000080FF, 0, 4'b1111, 32'h0);
        do_req(1, 0, F_W,  32'h0,  32'h0,        32'h80FF7F01, 0, 4'b1111, 32'h0);
        do_req(1, 1, F_H,  32'h22, 32'h00001234, 32'h0,        0, 4'b1100, 32'h12341234);
        do_req(1, 1, F_W,  32'h24, 32'hCAFEF00D, 32'h0,        0, 4'b1111, 32'hCAFEF00D);
        do_req(1, 1, F_B,  32'h20, 32'hFFFFFF5A, 32'h0,        0, 4'b0001, 32'h5A5A5A5A);
        do_req(1, 0, F_H,  32'h22, 32'h0,        32'h00001234, 0, 4'b1111, 32'h0);
        do_req(1, 0, F_B,  32'h20, 32'h0,        32'h0000005A, 0, 4'b1111, 32'h0);
        do_req(0, 0, F_W,  32'h24, 32'h0,        32'hCAFEF00D, 0, 4'b1111, 32'h0);
        do_req(0, 0, F_W,  32'h10, 32'h0,        32'hA5ADBEEF, 0, 4'b1111, 32'h0);

        do_req(1, 0, F_W,   32'h6,        32'h0, 32'h0, 1, 4'b0000, 32'h0);
        do_req(0, 0, F_W,   32'h00040000, 32'h0, 32'h0, 1, 4'b0000, 32'h0);
        do_req(0, 0, F_W,   32'h2,        32'h0, 32'h0, 1, 4'b0000, 32'h0);
        do_req(1, 0, F_H,   32'h1,        32'h0, 32'h0, 1, 4'b0000, 32'h0);
        do_req(1, 0, 3'b011, 32'h0,       32'h0, 32'h0, 1, 4'b0000, 32'h0);
        do_req(1, 1, F_BU,  32'h0,        32'h0, 32'h0, 1, 4'b0000, 32'h0);
        do_req(1, 0, F_B,   32'h00040000, 32'h0, 32'h0, 1, 4'b0000, 32'h0);

        // both ports held from reset: grants alternate starting with port 0
        reset = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_funct3 = F_W; bus.ls_addr = 32'h24;
        @(negedge clk);
        reset = 1'b1;
        k = cyc;
        for (int i = 0; i < 4; i++) begin
            r.cyc = k + 1 + 4 * i; r.we = 1'b0; r.be = 4'b1111; r.wdata = 32'h0;
            r.addr = (i % 2 == 0) ? 16'd4 : 16'd9;
            exp_ram.push_back(r);
            a.port = (i % 2 == 1); a.err = 1'b0; a.cyc = k + 3 + 4 * i;
            a.rdata = (i % 2 == 0) ? 32'hA5ADBEEF : 32'hCAFEF00D;
            exp_ack.push_back(a);
        end
        while (cyc < k + 15) @(negedge clk);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        @(negedge clk);

        // reset while the load is in WAIT: no ack may follow
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_funct3 = F_W; bus.ls_addr = 32'h24;
        k = cyc;
        r.cyc = k + 1; r.we = 1'b0; r.addr = 16'd9; r.be = 4'b1111; r.wdata = 32'h0;
        exp_ram.push_back(r);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero("reset_mid_access");
        bus.ls_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        do_req(1, 0, F_W, 32'h24, 32'h0, 32'hCAFEF00D, 0, 4'b1111, 32'h0);

        repeat (4) @(negedge clk);
        total++;
        if (exp_ack.size() != 0) begin
            bad++;
            $display("FAIL ack_queue: %0d acks outstanding, required 0", exp_ack.size());
        end
        total++;
        if (exp_ram.size() != 0) begin
            bad++;
            $display("FAIL ram_queue: %0d RAM commands outstanding, required 0", exp_ram.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester controller that shares the single-port data RAM between instruction fetch (port 0) and load/store (port 1).
- Arbitrates with round-robin priority and a req/ack handshake.
- Sequences each RAM access.
- Generates byte enables for SB/SH/SW.
- Formats read data for LB/LH/LW/LBU/LHU.
- Flags misaligned and out-of-range accesses.
Sits between the fetch/memory pipeline stages and the RAM array.

Parameters:
ADDR_W, 16, word-address width of the RAM; valid byte addresses are 0 .. 4*2**ADDR_W-1.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  port 0 fetch request, held until if_ack
if_addr  in  32  port 0 byte address (word read only)
if_ack  out  1  port 0 one-cycle completion pulse
if_rdata  out  32  port 0 read word, valid with if_ack
if_err  out  1  port 0 misaligned/out-of-range, valid with if_ack
ls_req  in  1  port 1 load/store request, held until ls_ack
ls_we  in  1  port 1: 1 = store, 0 = load
ls_funct3  in  3  port 1 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
ls_addr  in  32  port 1 byte address
ls_wdata  in  32  port 1 store data, right-aligned
ls_ack  out  1  port 1 one-cycle completion pulse
ls_rdata  out  32  port 1 extended load data, valid with ls_ack
ls_err  out  1  port 1 error, valid with ls_ack
ram_en  out  1  RAM command strobe
ram_we  out  1  RAM write
ram_addr  out  ADDR_W  RAM word address
ram_be  out  4  RAM byte enables, bit i = byte i (little-endian)
ram_wdata  out  32  RAM write data, lane-shifted
ram_rdata  in  32  RAM read word, valid the cycle after ram_en with ram_we=0

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - All outputs 0.
  - last_grant=1, so port 0 wins the first tie.
  - Reset mid-access abandons the transaction; no ack is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port != last_grant.
  - Latch that port's address, funct3, we and wdata; update last_grant.
  - Check the request:
    - misaligned: H/HU with addr[0]!=0; W or fetch with addr[1:0]!=0.
    - illegal: funct3 011/110/111, or BU/HU with we=1.
    - out of range: addr[31:ADDR_W+2]!=0.
    - Any failure -> RESP with err=1.
  - Otherwise -> ISSUE.
- ISSUE (1 cycle):
  - ram_en=1, ram_addr=addr[ADDR_W+1:2], ram_we=latched we.
  - Store byte enables: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111.
  - ram_wdata = wdata replicated into the addressed lane(s).
  - Loads/fetch: ram_be=4'b1111.
  - Next state WAIT.
- WAIT (1 cycle):
  - ram_en=0; sample ram_rdata.
  - Select the byte or half by addr[1:0].
  - Sign-extend B/H; zero-extend BU/HU; W unchanged.
  - Register the result into the granted port's rdata.
  - Next state RESP.
- RESP (1 cycle):
  - Granted port ack=1; err as determined.
  - rdata=0 on error and on stores.
  - Next state IDLE.
- Latency: req sampled at edge N -> ram_en during N+1 -> ack during N+3. Error ack during N+1.
- Throughput: one access per 4 cycles; back-to-back requests from the same port re-arbitrate in IDLE.
- ack is never asserted on both ports in the same cycle.
- ack is asserted only for the granted port.
- A requester dropping req before ack is a protocol violation; the controller still completes the access and pulses ack.
- rdata/err hold their value until the next ack on that port.
- ram_* outputs are registered.
- ram_we, ram_be and ram_wdata are 0 whenever ram_en=0.

Test Plan:
1. Reset, then fetch if_addr=0x10 with RAM word 4 = 0xDEADBEEF -> ram_en cycle N+1 with ram_addr=4; if_ack at N+3 with if_rdata=0xDEADBEEF, if_err=0.
2. SB ls_addr=0x13, ls_wdata=0x000000A5 -> ram_be=4'b1000, ram_wdata[31:24]=0xA5, ram_we=1 at N+1; ls_ack at N+3 with ls_rdata=0.
3. RAM word 0 = 0x80FF7F01: LB addr 0x1 -> 0x0000007F; LB addr 0x2 -> 0xFFFFFFFF; LBU addr 0x3 -> 0x00000080; LH addr 0x2 -> 0xFFFF80FF; LHU addr 0x2 -> 0x000080FF.
4. if_req and ls_req both held continuously from reset -> grants alternate port0, port1, port0, port1; ack pulses spaced 4 cycles apart; never simultaneous.
5. LW ls_addr=0x6, and fetch if_addr=0x0004_0000 with ADDR_W=16 -> err ack at N+1, ram_en never asserted.
6. Assert reset low during WAIT of a load -> all outputs 0 immediately; no ls_ack after release; the next request completes normally in 3 cycles.
